sort_stream_adapter: RTL and testbench

- Streaming wrapper around the 4-input, 4-bit combinational sorting network.
- Upstream side: collects a serial valid/ready stream of 4-bit values into groups of four and drives them to the sorter inputs.
- Downstream side: captures the sorter outputs and re-serialises them onto a valid/ready output stream, with a last-of-group flag.
- Input and output buffers are independent, so group N+1 can fill while group N drains.

---
 rtl/sort_stream_adapter.sv | 78 +++++++
 tb/tb_sort_stream_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_adapter.sv
// Streaming wrapper for a 4-input combinational sorter: packs 4 serial elements into the sorter, replays its outputs serially.
// Latency: one idle cycle after the 4th accept. Backpressure: in_ready drops while a full group waits for the output buffer.
module sort_stream_adapter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] sort_a,
   output logic [WIDTH-1:0] sort_b,
   output logic [WIDTH-1:0] sort_c,
   output logic [WIDTH-1:0] sort_d,
   input  logic [WIDTH-1:0] sorted_a,
   input  logic [WIDTH-1:0] sorted_b,
   input  logic [WIDTH-1:0] sorted_c,
   input  logic [WIDTH-1:0] sorted_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   logic [2:0]       in_cnt;
   logic [WIDTH-1:0] ibuf [4];
   logic [WIDTH-1:0] obuf [4];
   logic             out_busy;
   logic [1:0]       out_idx;
   logic             load;

   assign in_ready  = (in_cnt != 3'd4);
   // A full input group moves across only once the previous group has fully drained.
   assign load      = (in_cnt == 3'd4) && !out_busy;

   assign sort_a    = ibuf[0];
   assign sort_b    = ibuf[1];
   assign sort_c    = ibuf[2];
   assign sort_d    = ibuf[3];

   assign out_valid = out_busy;
   assign out_data  = out_busy ? obuf[out_idx] : '0;
   assign out_last  = out_busy && (out_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_cnt   <= '0;
         out_busy <= 1'b0;
         out_idx  <= '0;
         for (int i = 0; i < 4; i++) begin
            ibuf[i] <= '0;
            obuf[i] <= '0;
         end
      end else begin
         if (in_valid && in_ready) begin
            ibuf[in_cnt[1:0]] <= in_data;
            in_cnt            <= in_cnt + 3'd1;
         end
         if (load) begin
            obuf[0]  <= sorted_a;
            obuf[1]  <= sorted_b;
            obuf[2]  <= sorted_c;
            obuf[3]  <= sorted_d;
            in_cnt   <= '0;
            out_busy <= 1'b1;
            out_idx  <= '0;
         end else if (out_busy && out_ready) begin
            if (out_idx == 2'd3) begin
               out_busy <= 1'b0;
               out_idx  <= '0;
            end else begin
               out_idx <= out_idx + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter: ascending sorter model (or fixed stub) plus directed and random checks against a queue model.
module tb_sort_stream_adapter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [3:0] sort_a, sort_b, sort_c, sort_d;
   logic [3:0] sorted_a, sorted_b, sorted_c, sorted_d;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_last;
   logic       stub_mode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sort_stream_adapter #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sort_a(sort_a), .sort_b(sort_b), .sort_c(sort_c), .sort_d(sort_d),
      .sorted_a(sorted_a), .sorted_b(sorted_b), .sorted_c(sorted_c), .sorted_d(sorted_d),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   // Sorter environment: 5-comparator ascending network, or a fixed 1,3,5,7 stub.
   function automatic logic [3:0] mn(input logic [3:0] x, input logic [3:0] y);
      return (x < y) ? x : y;
   endfunction
   function automatic logic [3:0] mx(input logic [3:0] x, input logic [3:0] y);
      return (x < y) ? y : x;
   endfunction

   logic [3:0] l1, h1, l2, h2, m1, m2;
   assign l1 = mn(sort_a, sort_b);
   assign h1 = mx(sort_a, sort_b);
   assign l2 = mn(sort_c, sort_d);
   assign h2 = mx(sort_c, sort_d);
   assign m1 = mx(l1, l2);
   assign m2 = mn(h1, h2);
   assign sorted_a = stub_mode ? 4'd1 : mn(l1, l2);
   assign sorted_b = stub_mode ? 4'd3 : mn(m1, m2);
   assign sorted_c = stub_mode ? 4'd5 : mx(m1, m2);
   assign sorted_d = stub_mode ? 4'd7 : mx(h1, h2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] v);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Drains one group with out_ready held high; ev holds the 4 expected beats, first in the top nibble.
   task automatic expect_group(input string tag, input logic [15:0] ev);
      int k;
      int n;
      k = 0;
      n = 0;
      out_ready = 1'b1;
      while (k < 4 && n < 50) begin
         if (out_valid) begin
            chk({tag, "_data"}, 32'(out_data), 32'(ev[15-4*k -: 4]));
            chk({tag, "_last"}, 32'(out_last), 32'(k == 3));
            k++;
         end
         step();
         n++;
      end
      chk({tag, "_beats"}, k, 4);
   endtask

   logic [3:0] ov_exp [9];
   logic [8:0] vv_exp;
   logic [3:0] exp_q [$];
   logic [3:0] grp [$];
   logic [3:0] tmp [$];

   initial begin
      int n, beats, sent, rcvd, cyc;
      logic stalled;
      logic [3:0] prev;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stub_mode = 1'b0;
      @(negedge clk);

      // Reset then idle
      step(); step();
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_sort", 32'({sort_a, sort_b, sort_c, sort_d}), 32'h0000);
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Single group, real sorter, exact latency
      out_ready = 1'b1;
      send(4'd9); send(4'd2); send(4'd7); send(4'd4);
      chk("g1_sort_in", 32'({sort_a, sort_b, sort_c, sort_d}), 32'h9274);
      chk("g1_in_ready_full", 32'(in_ready), 32'd0);
      chk("g1_no_valid_yet", 32'(out_valid), 32'd0);
      step();
      ov_exp[0] = 4'd2; ov_exp[1] = 4'd4; ov_exp[2] = 4'd7; ov_exp[3] = 4'd9;
      for (int i = 0; i < 4; i++) begin
         chk("g1_valid", 32'(out_valid), 32'd1);
         chk("g1_data", 32'(out_data), 32'(ov_exp[i]));
         chk("g1_last", 32'(out_last), 32'(i == 3));
         if (i == 0) chk("g1_in_ready_after_load", 32'(in_ready), 32'd1);
         step();
      end
      chk("g1_idle_after", 32'(out_valid), 32'd0);

      // Backpressure against the stub sorter
      stub_mode = 1'b1;
      out_ready = 1'b0;
      send(4'd0); send(4'd11); send(4'd6); send(4'd2);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
      beats = 0; stalled = 1'b0; prev = '0; n = 0;
      while (beats < 4 && n < 40) begin
         out_ready = n[0];
         if (stalled) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'(prev));
         end
         if (out_valid && out_ready) begin
            chk("bp_data", 32'(out_data), 32'(2 * beats + 1));
            chk("bp_last", 32'(out_last), 32'(beats == 3));
            beats++;
         end
         stalled = out_valid && !out_ready;
         prev = out_data;
         step();
         n++;
      end
      chk("bp_beats", beats, 4);
      stub_mode = 1'b0;
      out_ready = 1'b0;

      // Overlap: A drains while B waits in the input buffer
      send(4'd3); send(4'd12); send(4'd0); send(4'd7);
      send(4'd15); send(4'd1); send(4'd9); send(4'd4);
      chk("ov_in_ready", 32'(in_ready), 32'd0);
      chk("ov_sort_b", 32'({sort_a, sort_b, sort_c, sort_d}), 32'hF194);
      step();
      chk("ov_in_ready_hold", 32'(in_ready), 32'd0);
      chk("ov_sort_b_hold", 32'({sort_a, sort_b, sort_c, sort_d}), 32'hF194);
      ov_exp[0] = 4'd0; ov_exp[1] = 4'd3; ov_exp[2] = 4'd7; ov_exp[3] = 4'd12; ov_exp[4] = 4'd0;
      ov_exp[5] = 4'd1; ov_exp[6] = 4'd4; ov_exp[7] = 4'd9; ov_exp[8] = 4'd15;
      vv_exp = 9'b111101111;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("ov_valid", 32'(out_valid), 32'(vv_exp[8-i]));
         if (vv_exp[8-i]) begin
            chk("ov_data", 32'(out_data), 32'(ov_exp[i]));
            chk("ov_last", 32'(out_last), 32'(i == 3 || i == 8));
         end
         step();
      end
      chk("ov_idle_after", 32'(out_valid), 32'd0);

      // Reset during a stalled drain with a partial group pending
      out_ready = 1'b0;
      send(4'd5); send(4'd6); send(4'd7); send(4'd8);
      send(4'd1); send(4'd2);
      chk("mr_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_in_ready", 32'(in_ready), 32'd1);
      chk("mr_sort", 32'({sort_a, sort_b, sort_c, sort_d}), 32'h0000);
      rst_n = 1'b1;
      send(4'd15); send(4'd0); send(4'd15); send(4'd0);
      chk("mr_sort_new", 32'({sort_a, sort_b, sort_c, sort_d}), 32'hF0F0);
      expect_group("mr_grp", 16'h00FF);

      // Random stress against the queue model
      sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; prev = '0;
      while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 2) != 0);
         if (stalled) chk("st_hold_data", 32'(out_data), 32'(prev));
         if (in_valid && in_ready) begin
            grp.push_back(in_data);
            sent++;
            if (grp.size() == 4) begin
               tmp = grp;
               tmp.sort();
               foreach (tmp[i]) exp_q.push_back(tmp[i]);
               grp.delete();
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("st_unexpected_beat", 32'd1, 32'd0);
            end else begin
               chk("st_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            chk("st_last", 32'(out_last), 32'(rcvd % 4 == 3));
            rcvd++;
         end
         stalled = out_valid && !out_ready;
         prev = out_data;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      chk("st_received", rcvd, 1000);
      chk("st_leftover", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
